// File: rtl/sw_seq_multi.sv
// sw_seq_multi: multi-axis DAC switch sequencer.
// Each axis engine runs on a sw_req rising edge. It steps through a per-step
// duration table, forward or backward. For each step it drives a hi/lo code
// per DAC channel from the step pattern. After the last step it waits a
// programmable ack delay, then pulses sw_ack for one cycle.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   sw_req[a]          request, rising edge starts a run on axis a
//   sw_abort[a]        level abort, honoured in RUN / ACK_WAIT
//   sw_time_forward    step k duration at [k*TIME_W +: TIME_W]
//   sw_time_backward   same layout, used for backward runs
//   sw_pattern         bit [k*NUM_DAC+d]: DAC d uses hi code in step k
//   sw_code_hi/lo      DAC codes for active / inactive channels
//   reg_dir_mode       0 toggle per run, 1 fwd, 2 bwd, 3 fwd
//   reg_sw_ack_time    cycles between last step and ack
//   dac_sw             axis a channel d at [(a*NUM_DAC+d)*DAC_W +: DAC_W]
//   sw_busy / sw_ack / sw_ack_any / sw_overrun  status per axis
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for a request edge; codes hold
// RUN      | stepping through the latched table
// ACK_WAIT | counting the latched ack delay, final codes hold
// ACK      | one-cycle completion pulse
module sw_seq_multi #(
   parameter int NUM_AXIS = 2,
   parameter int NUM_DAC  = 4,
   parameter int DAC_W    = 12,
   parameter int NUM_STEP = 7,
   parameter int TIME_W   = 24
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_AXIS-1:0]                sw_req,
   input  logic [NUM_AXIS-1:0]                sw_abort,
   input  logic [NUM_STEP*TIME_W-1:0]         sw_time_forward,
   input  logic [NUM_STEP*TIME_W-1:0]         sw_time_backward,
   input  logic [NUM_STEP*NUM_DAC-1:0]        sw_pattern,
   input  logic [DAC_W-1:0]                   sw_code_hi,
   input  logic [DAC_W-1:0]                   sw_code_lo,
   input  logic [1:0]                         reg_dir_mode,
   input  logic [31:0]                        reg_sw_ack_time,
   output logic [NUM_AXIS*NUM_DAC*DAC_W-1:0]  dac_sw,
   output logic [NUM_AXIS-1:0]                sw_busy,
   output logic [NUM_AXIS-1:0]                sw_ack,
   output logic                               sw_ack_any,
   output logic [NUM_AXIS-1:0]                sw_overrun
);

   localparam int STEP_W = (NUM_STEP > 1) ? $clog2(NUM_STEP) : 1;
   localparam int TBL_W  = NUM_STEP * TIME_W;
   localparam int PAT_W  = NUM_STEP * NUM_DAC;
   localparam int CODE_W = NUM_DAC * DAC_W;
   localparam logic [STEP_W-1:0] LAST_IDX = STEP_W'(NUM_STEP - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RUN      = 2'd1,
      S_ACK_WAIT = 2'd2,
      S_ACK      = 2'd3
   } state_t;

   // A zero duration is stretched to one cycle.
   function automatic logic [TIME_W-1:0] step_dur(input logic [TBL_W-1:0]  tbl,
                                                  input logic [STEP_W-1:0] k);
      logic [TIME_W-1:0] t;
      t = tbl[int'(k)*TIME_W +: TIME_W];
      return (t == '0) ? TIME_W'(1) : t;
   endfunction

   function automatic logic [CODE_W-1:0] step_codes(input logic [PAT_W-1:0]  pat,
                                                    input logic [STEP_W-1:0] k,
                                                    input logic [DAC_W-1:0]  hi,
                                                    input logic [DAC_W-1:0]  lo);
      logic [CODE_W-1:0] c;
      c = '0;
      for (int d = 0; d < NUM_DAC; d++)
         c[d*DAC_W +: DAC_W] = pat[int'(k)*NUM_DAC + d] ? hi : lo;
      return c;
   endfunction

   // A request held high through reset is blocked until it has been seen low,
   // so only a genuine rising edge after reset can start a run.
   logic [NUM_AXIS-1:0] req_q, req_d, req_block;

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q     <= '0;
         req_d     <= '0;
         req_block <= sw_req;
      end else begin
         req_block <= req_block & sw_req;
         req_q     <= sw_req & ~req_block;
         req_d     <= req_q;
      end
   end

   for (genvar a = 0; a < NUM_AXIS; a++) begin : g_axis
      state_t              state_q, state_n;
      logic [STEP_W-1:0]   step_q, step_nxt, first_step;
      logic                dir_q, dir_flag_q, dir_start;
      logic [TBL_W-1:0]    tbl_q, tbl_sel;
      logic [PAT_W-1:0]    pat_q;
      logic [TIME_W-1:0]   tcnt_q;
      logic [31:0]         acnt_q;
      logic [CODE_W-1:0]   code_q;
      logic                overrun_q;
      logic                req_edge, last_step, start, advance, abort_go, done;

      assign req_edge = req_q[a] & ~req_d[a];

      always_comb begin
         state_n    = state_q;
         start      = 1'b0;
         advance    = 1'b0;
         abort_go   = 1'b0;
         done       = 1'b0;
         dir_start  = (reg_dir_mode == 2'd2) | ((reg_dir_mode == 2'd0) & dir_flag_q);
         tbl_sel    = dir_start ? sw_time_backward : sw_time_forward;
         first_step = dir_start ? LAST_IDX : '0;
         last_step  = dir_q ? (step_q == '0) : (step_q == LAST_IDX);
         step_nxt   = dir_q ? (step_q - STEP_W'(1)) : (step_q + STEP_W'(1));
         case (state_q)
            S_IDLE: begin
               if (req_edge) begin
                  start   = 1'b1;
                  state_n = S_RUN;
               end
            end
            S_RUN: begin
               if (sw_abort[a]) begin
                  abort_go = 1'b1;
                  state_n  = S_IDLE;
               end else if (tcnt_q == TIME_W'(1)) begin
                  if (last_step)
                     state_n = (acnt_q == '0) ? S_ACK : S_ACK_WAIT;
                  else
                     advance = 1'b1;
               end
            end
            S_ACK_WAIT: begin
               if (sw_abort[a]) begin
                  abort_go = 1'b1;
                  state_n  = S_IDLE;
               end else if (acnt_q == 32'd1) begin
                  state_n = S_ACK;
               end
            end
            S_ACK: begin
               done    = 1'b1;
               state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
         endcase
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            dir_q      <= 1'b0;
            dir_flag_q <= 1'b0;
            tbl_q      <= '0;
            pat_q      <= '0;
            tcnt_q     <= '0;
            acnt_q     <= '0;
            code_q     <= '0;
            overrun_q  <= 1'b0;
         end else begin
            state_q <= state_n;
            if (req_edge && (state_q != S_IDLE))
               overrun_q <= 1'b1;
            // The ack counter is loaded at start and left alone during RUN,
            // so it doubles as the latched copy of the ack delay.
            if (start) begin
               dir_q  <= dir_start;
               tbl_q  <= tbl_sel;
               pat_q  <= sw_pattern;
               acnt_q <= reg_sw_ack_time;
               step_q <= first_step;
               tcnt_q <= step_dur(tbl_sel, first_step);
               code_q <= step_codes(sw_pattern, first_step, sw_code_hi, sw_code_lo);
            end else if (advance) begin
               step_q <= step_nxt;
               tcnt_q <= step_dur(tbl_q, step_nxt);
               code_q <= step_codes(pat_q, step_nxt, sw_code_hi, sw_code_lo);
            end else if (state_q == S_RUN) begin
               tcnt_q <= tcnt_q - TIME_W'(1);
            end
            if (state_q == S_ACK_WAIT)
               acnt_q <= acnt_q - 32'd1;
            if (abort_go)
               code_q <= {NUM_DAC{sw_code_lo}};
            if (done)
               dir_flag_q <= ~dir_flag_q;
         end
      end

      assign sw_busy[a]    = (state_q != S_IDLE);
      assign sw_ack[a]     = (state_q == S_ACK);
      assign sw_overrun[a] = overrun_q;
      assign dac_sw[a*CODE_W +: CODE_W] = code_q;
   end

   assign sw_ack_any = |sw_ack;

endmodule

// File: tb/tb_sw_seq_multi.sv
// Directed bench for sw_seq_multi: forward/backward runs, direction modes,
// zero durations, overrun, abort with a concurrent axis, reset mid-run.
module tb_sw_seq_multi;

   localparam int NUM_AXIS = 2;
   localparam int NUM_DAC  = 4;
   localparam int DAC_W    = 12;
   localparam int NUM_STEP = 7;
   localparam int TIME_W   = 24;

   logic                              clk = 1'b0;
   logic                              rst;
   logic [NUM_AXIS-1:0]               sw_req;
   logic [NUM_AXIS-1:0]               sw_abort;
   logic [NUM_STEP*TIME_W-1:0]        sw_time_forward;
   logic [NUM_STEP*TIME_W-1:0]        sw_time_backward;
   logic [NUM_STEP*NUM_DAC-1:0]       sw_pattern;
   logic [DAC_W-1:0]                  sw_code_hi;
   logic [DAC_W-1:0]                  sw_code_lo;
   logic [1:0]                        reg_dir_mode;
   logic [31:0]                       reg_sw_ack_time;
   logic [NUM_AXIS*NUM_DAC*DAC_W-1:0] dac_sw;
   logic [NUM_AXIS-1:0]               sw_busy;
   logic [NUM_AXIS-1:0]               sw_ack;
   logic                              sw_ack_any;
   logic [NUM_AXIS-1:0]               sw_overrun;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   sw_seq_multi #(
      .NUM_AXIS(NUM_AXIS), .NUM_DAC(NUM_DAC), .DAC_W(DAC_W),
      .NUM_STEP(NUM_STEP), .TIME_W(TIME_W)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .sw_req           (sw_req),
      .sw_abort         (sw_abort),
      .sw_time_forward  (sw_time_forward),
      .sw_time_backward (sw_time_backward),
      .sw_pattern       (sw_pattern),
      .sw_code_hi       (sw_code_hi),
      .sw_code_lo       (sw_code_lo),
      .reg_dir_mode     (reg_dir_mode),
      .reg_sw_ack_time  (reg_sw_ack_time),
      .dac_sw           (dac_sw),
      .sw_busy          (sw_busy),
      .sw_ack           (sw_ack),
      .sw_ack_any       (sw_ack_any),
      .sw_overrun       (sw_overrun)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Step k drives hi on channel k%4 only.
   function automatic logic [47:0] exp_codes(input int k);
      logic [47:0] c;
      for (int d = 0; d < NUM_DAC; d++)
         c[d*DAC_W +: DAC_W] = (d == k % 4) ? sw_code_hi : sw_code_lo;
      return c;
   endfunction

   // Expected {busy, ack, codes} of one axis, c cycles after the sampling edge
   // (c >= 1), for uniform step duration d and ack delay a.
   function automatic logic [49:0] axis_model(input int c, input bit bwd, input int d, input int a);
      int  j, k, last;
      last = 1 + NUM_STEP*d + a;
      j    = (c <= NUM_STEP*d) ? (c - 1) / d : NUM_STEP - 1;
      k    = bwd ? NUM_STEP - 1 - j : j;
      return {(c >= 1 && c <= last), (c == last), exp_codes(k)};
   endfunction

   task automatic set_tables(input int fd, input int bd, input int a);
      for (int k = 0; k < NUM_STEP; k++) begin
         sw_time_forward[k*TIME_W +: TIME_W]  = TIME_W'(fd);
         sw_time_backward[k*TIME_W +: TIME_W] = TIME_W'(bd);
      end
      reg_sw_ack_time = 32'(a);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Runs axis 0 and checks status and codes every cycle. With glitch set,
   // sw_req drops and rises again mid-run to produce an overrun.
   task automatic run_seq(input string tag, input bit bwd, input int d, input int a, input bit glitch);
      int          last;
      logic [49:0] m;
      last = 1 + NUM_STEP*d + a;
      sw_req[0] = 1'b1;
      for (int c = 0; c <= last + 1; c++) begin
         @(negedge clk);
         if (c >= 1) begin
            m = axis_model(c, bwd, d, a);
            check(tag, {sw_busy, sw_ack, sw_ack_any, dac_sw[47:0]},
                  {1'b0, m[49], 1'b0, m[48], m[48], m[47:0]});
         end
         if (glitch && c == 5) sw_req[0] = 1'b0;
         if (glitch && c == 7) sw_req[0] = 1'b1;
      end
      sw_req[0] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [49:0] m0, m1;
      rst = 1'b1;
      sw_req = '0;
      sw_abort = '0;
      sw_pattern = '0;
      for (int k = 0; k < NUM_STEP; k++) sw_pattern[k*NUM_DAC + k % 4] = 1'b1;
      sw_code_hi = 12'hFFF;
      sw_code_lo = 12'h000;
      reg_dir_mode = 2'd1;
      sw_time_forward = '0;
      sw_time_backward = '0;
      set_tables(2, 2, 3);
      repeat (3) @(negedge clk);
      check("reset_outputs", {sw_busy, sw_ack, sw_ack_any, sw_overrun, dac_sw}, '0);
      rst = 1'b0;
      @(negedge clk);

      // forward, T=2, A=3: ack 18 cycles after the sampling edge
      run_seq("fwd_run", 1'b0, 2, 3, 1'b0);

      // mode 0: forward then backward table in reverse order
      do_reset();
      reg_dir_mode = 2'd0;
      set_tables(2, 1, 3);
      run_seq("mode0_run1_fwd", 1'b0, 2, 3, 1'b0);
      run_seq("mode0_run2_bwd", 1'b1, 1, 3, 1'b0);

      reg_dir_mode = 2'd2;
      run_seq("mode2_run1_bwd", 1'b1, 1, 3, 1'b0);
      run_seq("mode2_run2_bwd", 1'b1, 1, 3, 1'b0);

      // all T=0, A=0: one cycle per step, ack 8 cycles after edge
      reg_dir_mode = 2'd1;
      set_tables(0, 0, 0);
      run_seq("zero_dur", 1'b0, 1, 0, 1'b0);

      // request edge during RUN: overrun, timing unchanged
      check("overrun_before", sw_overrun, 2'b00);
      set_tables(2, 2, 3);
      run_seq("overrun_run", 1'b0, 2, 3, 1'b1);
      check("overrun_set", sw_overrun, 2'b01);
      repeat (5) @(negedge clk);
      check("overrun_sticky", sw_overrun, 2'b01);

      // abort axis 0 at step 3 while axis 1 runs the same sequence
      sw_code_lo = 12'h123;
      sw_req = 2'b11;
      for (int c = 0; c <= 20; c++) begin
         @(negedge clk);
         if (c >= 1) begin
            m1 = axis_model(c, 1'b0, 2, 3);
            m0 = (c <= 7) ? axis_model(c, 1'b0, 2, 3) : {2'b00, {4{sw_code_lo}}};
            check("abort_concurrent", {sw_busy, sw_ack, sw_ack_any, dac_sw},
                  {m1[49], m0[49], m1[48], m0[48], m1[48] | m0[48], m1[47:0], m0[47:0]});
         end
         if (c == 7) sw_abort[0] = 1'b1;
         if (c == 8) sw_abort[0] = 1'b0;
      end
      sw_req = 2'b00;
      check("overrun_after_abort", sw_overrun, 2'b01);

      // reset in ACK_WAIT with sw_req held high
      sw_code_lo = 12'h000;
      set_tables(1, 1, 20);
      @(negedge clk);
      sw_req[0] = 1'b1;
      for (int c = 0; c <= 11; c++) begin
         @(negedge clk);
         if (c == 11) check("ackwait_busy", {sw_busy, sw_ack}, 4'b0100);
      end
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_outputs", {sw_busy, sw_ack, sw_ack_any, sw_overrun, dac_sw}, '0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         check("rst_req_held", {sw_busy, sw_ack, sw_ack_any, sw_overrun}, '0);
      end
      sw_req[0] = 1'b0;
      @(negedge clk);
      set_tables(1, 1, 2);
      run_seq("rerun_after_rst", 1'b0, 1, 2, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
